// File: rtl/as_unit_pkg.sv
// Shared register map, control-bit positions and helper types for the
// audio synthesiser register file.
package as_unit_pkg;

  localparam int CH_STRIDE = 16;

  localparam logic [3:0] CH_CTRL             = 4'd0;
  localparam logic [3:0] CH_PHASE_INC        = 4'd1;
  localparam logic [3:0] CH_GAIN             = 4'd2;
  localparam logic [3:0] CH_DUTY             = 4'd3;
  localparam logic [3:0] CH_ATTACK_STEP      = 4'd4;
  localparam logic [3:0] CH_DECAY_STEP       = 4'd5;
  localparam logic [3:0] CH_RELEASE_STEP     = 4'd6;
  localparam logic [3:0] CH_SUSTAIN_DURATION = 4'd7;
  localparam logic [3:0] CH_ATTACK_LEVEL     = 4'd8;
  localparam logic [3:0] CH_SUSTAIN_LEVEL    = 4'd9;

  localparam int G_COMMIT      = 0;
  localparam int G_STATUS      = 1;
  localparam int G_IRQ_PENDING = 2;
  localparam int G_IRQ_ENABLE  = 3;
  localparam int G_COUNT       = 4;

  localparam int CTRL_WAVE_EN    = 0;
  localparam int CTRL_ADSR_EN    = 1;
  localparam int CTRL_WAVE_START = 2;
  localparam int CTRL_ADSR_START = 3;

  typedef enum logic [1:0] {
    REGION_TABLE,
    REGION_CHANNEL,
    REGION_GLOBAL,
    REGION_UNMAPPED
  } region_e;

  // Per-channel data registers; CTRL is held separately because its arm
  // bits behave differently from the plain data words.
  typedef struct packed {
    logic [31:0] phase_inc;
    logic [15:0] gain;
    logic [31:0] duty;
    logic [31:0] attack_step;
    logic [31:0] decay_step;
    logic [31:0] release_step;
    logic [31:0] sustain_duration;
    logic [31:0] attack_level;
    logic [31:0] sustain_level;
  } ch_regs_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  strobe);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = strobe[b] ? new_value[8*b +: 8] : old_value[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/as_unit_regfile_if.sv
// Register bus between a host and the synthesiser register file:
// a byte-strobed write port and a one-cycle-latency read port.
interface as_unit_regfile_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  write_i;
  logic [ADDR_WIDTH-1:0] write_address_i;
  logic [31:0]           write_data_i;
  logic [3:0]            write_strobe_i;
  logic                  read_i;
  logic [ADDR_WIDTH-1:0] read_address_i;
  logic [31:0]           read_data_o;
  logic                  read_valid_o;

  modport master (
    output write_i, write_address_i, write_data_i, write_strobe_i,
    output read_i, read_address_i,
    input  read_data_o, read_valid_o
  );

  modport slave (
    input  write_i, write_address_i, write_data_i, write_strobe_i,
    input  read_i, read_address_i,
    output read_data_o, read_valid_o
  );
endinterface

// File: rtl/as_channel_registers.sv
// One channel's shadow/active register pair. Host writes land in shadow;
// a commit copies shadow to active and fires any armed start pulses.
module as_channel_registers
  import as_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_offset_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strobe_i,
  input  logic        commit_i,
  input  logic [3:0]  rd_offset_i,
  output logic [31:0] rd_data_o,
  output ch_regs_t    active_o,
  output logic        wave_enable_o,
  output logic        adsr_enable_o,
  output logic        wave_start_o,
  output logic        adsr_start_o
);

  ch_regs_t   shadow_q;
  logic [3:0] ctrl_q;

  // NOTE: these are a handful of flops rather than a RAM, so every one of
  // them is reset; a real memory array would be left unreset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q      <= '0;
      ctrl_q        <= '0;
      active_o      <= '0;
      wave_enable_o <= 1'b0;
      adsr_enable_o <= 1'b0;
      wave_start_o  <= 1'b0;
      adsr_start_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the later write below overrides the arm-clear when both hit ctrl_q.
      wave_start_o <= commit_i & ctrl_q[CTRL_WAVE_START];
      adsr_start_o <= commit_i & ctrl_q[CTRL_ADSR_START];
      if (commit_i) begin
        active_o                <= shadow_q;
        wave_enable_o           <= ctrl_q[CTRL_WAVE_EN];
        adsr_enable_o           <= ctrl_q[CTRL_ADSR_EN];
        ctrl_q[CTRL_WAVE_START] <= 1'b0;
        ctrl_q[CTRL_ADSR_START] <= 1'b0;
      end
      if (wr_en_i) begin
        case (wr_offset_i)
          CH_CTRL:             if (wr_strobe_i[0]) ctrl_q <= wr_data_i[3:0];
          CH_PHASE_INC:        shadow_q.phase_inc <= merge_bytes(shadow_q.phase_inc, wr_data_i, wr_strobe_i);
          CH_GAIN: begin
            if (wr_strobe_i[0]) shadow_q.gain[7:0]  <= wr_data_i[7:0];
            if (wr_strobe_i[1]) shadow_q.gain[15:8] <= wr_data_i[15:8];
          end
          CH_DUTY:             shadow_q.duty <= merge_bytes(shadow_q.duty, wr_data_i, wr_strobe_i);
          CH_ATTACK_STEP:      shadow_q.attack_step <= merge_bytes(shadow_q.attack_step, wr_data_i, wr_strobe_i);
          CH_DECAY_STEP:       shadow_q.decay_step <= merge_bytes(shadow_q.decay_step, wr_data_i, wr_strobe_i);
          CH_RELEASE_STEP:     shadow_q.release_step <= merge_bytes(shadow_q.release_step, wr_data_i, wr_strobe_i);
          CH_SUSTAIN_DURATION: shadow_q.sustain_duration <= merge_bytes(shadow_q.sustain_duration, wr_data_i, wr_strobe_i);
          CH_ATTACK_LEVEL:     shadow_q.attack_level <= merge_bytes(shadow_q.attack_level, wr_data_i, wr_strobe_i);
          CH_SUSTAIN_LEVEL:    shadow_q.sustain_level <= merge_bytes(shadow_q.sustain_level, wr_data_i, wr_strobe_i);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    rd_data_o = '0;
    case (rd_offset_i)
      CH_CTRL:             rd_data_o = {28'd0, ctrl_q};
      CH_PHASE_INC:        rd_data_o = shadow_q.phase_inc;
      CH_GAIN:             rd_data_o = {16'd0, shadow_q.gain};
      CH_DUTY:             rd_data_o = shadow_q.duty;
      CH_ATTACK_STEP:      rd_data_o = shadow_q.attack_step;
      CH_DECAY_STEP:       rd_data_o = shadow_q.decay_step;
      CH_RELEASE_STEP:     rd_data_o = shadow_q.release_step;
      CH_SUSTAIN_DURATION: rd_data_o = shadow_q.sustain_duration;
      CH_ATTACK_LEVEL:     rd_data_o = shadow_q.attack_level;
      CH_SUSTAIN_LEVEL:    rd_data_o = shadow_q.sustain_level;
      default:             rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/as_unit_regfile.sv
// Synthesiser register file: PCM table write-through, per-channel
// double-buffered parameters committed on a sample tick, and idle IRQs.
module as_unit_regfile
  import as_unit_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int TABLE_DEPTH = 1024,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  as_unit_regfile_if.slave                  bus,
  input  logic                              sample_tick_i,
  input  logic [CHANNELS-1:0]               adsr_idle_i,
  output logic                              table_write_o,
  output logic [$clog2(TABLE_DEPTH)-1:0]    table_addr_o,
  output logic [15:0]                       pcm_o,
  output logic [CHANNELS-1:0][31:0]         wave_frequency_o,
  output logic [CHANNELS-1:0][31:0]         duty_cycle_o,
  output logic [CHANNELS-1:0][31:0]         attack_step_o,
  output logic [CHANNELS-1:0][31:0]         decay_step_o,
  output logic [CHANNELS-1:0][31:0]         release_step_o,
  output logic [CHANNELS-1:0][31:0]         sustain_duration_o,
  output logic [CHANNELS-1:0][31:0]         attack_level_o,
  output logic [CHANNELS-1:0][31:0]         sustain_level_o,
  output logic [CHANNELS-1:0][15:0]         wave_gain_o,
  output logic [CHANNELS-1:0]               wave_enable_o,
  output logic [CHANNELS-1:0]               adsr_enable_o,
  output logic [CHANNELS-1:0]               wave_start_o,
  output logic [CHANNELS-1:0]               adsr_start_o,
  output logic                              irq_o
);

  localparam int TABLE_AW = $clog2(TABLE_DEPTH);
  localparam int G_BASE   = TABLE_DEPTH + CHANNELS * CH_STRIDE;

  function automatic region_e decode(input int addr);
    if (addr < TABLE_DEPTH)         return REGION_TABLE;
    if (addr < G_BASE)              return REGION_CHANNEL;
    if (addr < G_BASE + G_COUNT)    return REGION_GLOBAL;
    return REGION_UNMAPPED;
  endfunction

  int                    wr_addr, rd_addr, wr_ch, rd_ch;
  logic [ADDR_WIDTH-1:0] wr_rel, rd_rel;
  logic [3:0]            wr_off, rd_off;
  region_e               wr_region, rd_region;
  logic                  commit_req, do_commit;
  logic [CHANNELS-1:0]   wr_ch_sel, irq_clr;
  logic [31:0]           rd_next;
  logic [31:0]           ch_rd_data [CHANNELS];

  logic                  commit_pending_q;
  logic [CHANNELS-1:0]   irq_pending_q, irq_enable_q, prev_idle_q;

  // Channel blocks start at TABLE_DEPTH, so the offset relative to that base
  // splits cleanly into channel index (upper bits) and register (low nibble).
  always_comb begin
    wr_addr   = int'(bus.write_address_i);
    rd_addr   = int'(bus.read_address_i);
    wr_rel    = bus.write_address_i - ADDR_WIDTH'(TABLE_DEPTH);
    rd_rel    = bus.read_address_i - ADDR_WIDTH'(TABLE_DEPTH);
    wr_ch     = int'(wr_rel[ADDR_WIDTH-1:4]);
    rd_ch     = int'(rd_rel[ADDR_WIDTH-1:4]);
    wr_off    = wr_rel[3:0];
    rd_off    = rd_rel[3:0];
    wr_region = decode(wr_addr);
    rd_region = decode(rd_addr);

    commit_req = bus.write_i && (wr_addr == G_BASE + G_COMMIT) && bus.write_data_i[0];
    do_commit  = sample_tick_i && (commit_pending_q || commit_req);
    irq_clr    = (bus.write_i && wr_addr == G_BASE + G_IRQ_PENDING)
               ? bus.write_data_i[CHANNELS-1:0] : '0;
  end

  always_comb begin
    rd_next = '0;
    case (rd_region)
      REGION_CHANNEL: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (rd_ch == c) rd_next = ch_rd_data[c];
        end
      end
      REGION_GLOBAL: begin
        if (rd_addr == G_BASE + G_COMMIT)           rd_next = {31'd0, commit_pending_q};
        else if (rd_addr == G_BASE + G_STATUS)      rd_next = 32'(adsr_idle_i);
        else if (rd_addr == G_BASE + G_IRQ_PENDING) rd_next = 32'(irq_pending_q);
        else                                        rd_next = 32'(irq_enable_q);
      end
      default: rd_next = '0;
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ch_regs_t active;

    assign wr_ch_sel[c] = bus.write_i && (wr_region == REGION_CHANNEL) && (wr_ch == c);

    as_channel_registers u_regs (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .wr_en_i       (wr_ch_sel[c]),
      .wr_offset_i   (wr_off),
      .wr_data_i     (bus.write_data_i),
      .wr_strobe_i   (bus.write_strobe_i),
      .commit_i      (do_commit),
      .rd_offset_i   (rd_off),
      .rd_data_o     (ch_rd_data[c]),
      .active_o      (active),
      .wave_enable_o (wave_enable_o[c]),
      .adsr_enable_o (adsr_enable_o[c]),
      .wave_start_o  (wave_start_o[c]),
      .adsr_start_o  (adsr_start_o[c])
    );

    assign wave_frequency_o[c]   = active.phase_inc;
    assign wave_gain_o[c]        = active.gain;
    assign duty_cycle_o[c]       = active.duty;
    assign attack_step_o[c]      = active.attack_step;
    assign decay_step_o[c]       = active.decay_step;
    assign release_step_o[c]     = active.release_step;
    assign sustain_duration_o[c] = active.sustain_duration;
    assign attack_level_o[c]     = active.attack_level;
    assign sustain_level_o[c]    = active.sustain_level;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      commit_pending_q <= 1'b0;
      irq_pending_q    <= '0;
      irq_enable_q     <= '0;
      prev_idle_q      <= '1;   // idle-high straight out of reset is not an edge
      irq_o            <= 1'b0;
      table_write_o    <= 1'b0;
      table_addr_o     <= '0;
      pcm_o            <= '0;
      bus.read_valid_o <= 1'b0;
      bus.read_data_o  <= '0;
    end else begin
      if (do_commit)       commit_pending_q <= 1'b0;
      else if (commit_req) commit_pending_q <= 1'b1;

      // A rising idle edge wins over a same-cycle write-1-to-clear.
      irq_pending_q <= (irq_pending_q & ~irq_clr) | (adsr_idle_i & ~prev_idle_q);
      prev_idle_q   <= adsr_idle_i;
      if (bus.write_i && wr_addr == G_BASE + G_IRQ_ENABLE)
        irq_enable_q <= bus.write_data_i[CHANNELS-1:0];
      irq_o <= |(irq_pending_q & irq_enable_q);

      table_write_o <= bus.write_i && (wr_region == REGION_TABLE);
      if (bus.write_i && wr_region == REGION_TABLE) begin
        table_addr_o <= bus.write_address_i[TABLE_AW-1:0];
        pcm_o        <= bus.write_data_i[15:0];
      end

      bus.read_valid_o <= bus.read_i;
      bus.read_data_o  <= bus.read_i ? rd_next : '0;
    end
  end

endmodule

// File: tb/tb_as_unit_regfile.sv
// Self-checking bench for as_unit_regfile: directed register-map scenarios
// followed by random traffic compared against an array-based model.
module tb_as_unit_regfile;

  localparam int CH = 4;
  localparam int TD = 1024;
  localparam int AW = 12;
  localparam int G  = TD + CH * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick;
  logic [CH-1:0] idle;

  logic              table_write_o;
  logic [9:0]        table_addr_o;
  logic [15:0]       pcm_o;
  logic [CH-1:0][31:0] wave_frequency_o, duty_cycle_o, attack_step_o, decay_step_o;
  logic [CH-1:0][31:0] release_step_o, sustain_duration_o, attack_level_o, sustain_level_o;
  logic [CH-1:0][15:0] wave_gain_o;
  logic [CH-1:0]     wave_enable_o, adsr_enable_o, wave_start_o, adsr_start_o;
  logic              irq_o;

  as_unit_regfile_if #(.ADDR_WIDTH(AW)) bus ();

  as_unit_regfile #(.CHANNELS(CH), .TABLE_DEPTH(TD), .ADDR_WIDTH(AW)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .bus                (bus),
    .sample_tick_i      (tick),
    .adsr_idle_i        (idle),
    .table_write_o      (table_write_o),
    .table_addr_o       (table_addr_o),
    .pcm_o              (pcm_o),
    .wave_frequency_o   (wave_frequency_o),
    .duty_cycle_o       (duty_cycle_o),
    .attack_step_o      (attack_step_o),
    .decay_step_o       (decay_step_o),
    .release_step_o     (release_step_o),
    .sustain_duration_o (sustain_duration_o),
    .attack_level_o     (attack_level_o),
    .sustain_level_o    (sustain_level_o),
    .wave_gain_o        (wave_gain_o),
    .wave_enable_o      (wave_enable_o),
    .adsr_enable_o      (adsr_enable_o),
    .wave_start_o       (wave_start_o),
    .adsr_start_o       (adsr_start_o),
    .irq_o              (irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: register words indexed [channel][offset].
  logic [31:0] m_shadow [CH][16];
  logic [31:0] m_active [CH][16];
  logic        m_cp;
  logic [CH-1:0] m_pend, m_en, m_prev;
  logic        exp_rd_valid, exp_tw, exp_irq;
  logic [31:0] exp_rd_data;
  int          exp_taddr;
  logic [15:0] exp_pcm;
  logic [CH-1:0] exp_wstart, exp_astart;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] model_read(input int a);
    int c, o;
    if (a < TD) return 32'd0;
    if (a < G) begin
      c = (a - TD) / 16;
      o = (a - TD) % 16;
      return (o <= 9) ? m_shadow[c][o] : 32'd0;
    end
    if (a == G)     return {31'd0, m_cp};
    if (a == G + 1) return 32'(idle);
    if (a == G + 2) return 32'(m_pend);
    if (a == G + 3) return 32'(m_en);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int o = 0; o < 16; o++) begin
        m_shadow[c][o] = '0;
        m_active[c][o] = '0;
      end
    m_cp = 1'b0; m_pend = '0; m_en = '0; m_prev = '1;
    exp_rd_valid = 1'b0; exp_rd_data = '0; exp_tw = 1'b0; exp_irq = 1'b0;
    exp_taddr = 0; exp_pcm = '0; exp_wstart = '0; exp_astart = '0;
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    int wa, c, o;
    logic creq, dcommit;
    logic [CH-1:0] rise, clr;
    wa = int'(bus.write_address_i);
    exp_rd_valid = bus.read_i;
    exp_rd_data  = bus.read_i ? model_read(int'(bus.read_address_i)) : 32'd0;
    exp_tw = bus.write_i && (wa < TD);
    if (exp_tw) begin
      exp_taddr = wa;
      exp_pcm   = bus.write_data_i[15:0];
    end
    exp_irq = |(m_pend & m_en);
    creq    = bus.write_i && (wa == G) && bus.write_data_i[0];
    dcommit = tick && (m_cp || creq);
    exp_wstart = '0;
    exp_astart = '0;
    if (dcommit) begin
      for (int k = 0; k < CH; k++) begin
        for (int j = 0; j < 16; j++) m_active[k][j] = m_shadow[k][j];
        exp_wstart[k] = m_shadow[k][0][2];
        exp_astart[k] = m_shadow[k][0][3];
        m_shadow[k][0][3:2] = 2'b00;
      end
      m_cp = 1'b0;
    end else if (creq) begin
      m_cp = 1'b1;
    end
    if (bus.write_i && wa >= TD && wa < G) begin
      c = (wa - TD) / 16;
      o = (wa - TD) % 16;
      if (o == 0)
        m_shadow[c][o] = byte_merge(m_shadow[c][o], bus.write_data_i, bus.write_strobe_i) & 32'hF;
      else if (o == 2)
        m_shadow[c][o] = byte_merge(m_shadow[c][o], bus.write_data_i, bus.write_strobe_i) & 32'hFFFF;
      else if (o <= 9)
        m_shadow[c][o] = byte_merge(m_shadow[c][o], bus.write_data_i, bus.write_strobe_i);
    end
    rise = idle & ~m_prev;
    clr  = (bus.write_i && wa == G + 2) ? bus.write_data_i[CH-1:0] : '0;
    m_pend = (m_pend & ~clr) | rise;
    if (bus.write_i && wa == G + 3) m_en = bus.write_data_i[CH-1:0];
    m_prev = idle;
  endtask

  task automatic check_outputs();
    check("read_valid", 32'(bus.read_valid_o), 32'(exp_rd_valid));
    check("read_data", bus.read_data_o, exp_rd_data);
    check("table_write", 32'(table_write_o), 32'(exp_tw));
    check("table_addr", 32'(table_addr_o), 32'(exp_taddr));
    check("pcm", 32'(pcm_o), 32'(exp_pcm));
    check("irq", 32'(irq_o), 32'(exp_irq));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("wave_en[%0d]", c), 32'(wave_enable_o[c]), 32'(m_active[c][0][0]));
      check($sformatf("adsr_en[%0d]", c), 32'(adsr_enable_o[c]), 32'(m_active[c][0][1]));
      check($sformatf("wave_start[%0d]", c), 32'(wave_start_o[c]), 32'(exp_wstart[c]));
      check($sformatf("adsr_start[%0d]", c), 32'(adsr_start_o[c]), 32'(exp_astart[c]));
      check($sformatf("freq[%0d]", c), wave_frequency_o[c], m_active[c][1]);
      check($sformatf("gain[%0d]", c), 32'(wave_gain_o[c]), m_active[c][2]);
      check($sformatf("duty[%0d]", c), duty_cycle_o[c], m_active[c][3]);
      check($sformatf("attack_step[%0d]", c), attack_step_o[c], m_active[c][4]);
      check($sformatf("decay_step[%0d]", c), decay_step_o[c], m_active[c][5]);
      check($sformatf("release_step[%0d]", c), release_step_o[c], m_active[c][6]);
      check($sformatf("sustain_dur[%0d]", c), sustain_duration_o[c], m_active[c][7]);
      check($sformatf("attack_lvl[%0d]", c), attack_level_o[c], m_active[c][8]);
      check($sformatf("sustain_lvl[%0d]", c), sustain_level_o[c], m_active[c][9]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [31:0] data, input logic [3:0] strb = 4'hF);
    bus.write_i         = 1'b1;
    bus.write_address_i = AW'(addr);
    bus.write_data_i    = data;
    bus.write_strobe_i  = strb;
    cycle();
  endtask

  task automatic rd(input int addr);
    bus.read_i         = 1'b1;
    bus.read_address_i = AW'(addr);
    cycle();
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    cycle();
  endtask

  function automatic int rand_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 2)  return int'($urandom_range(0, TD - 1));
    if (sel < 7)  return TD + int'($urandom_range(0, CH * 16 - 1));
    if (sel < 9)  return G + int'($urandom_range(0, 3));
    return int'($urandom_range(G + 4, (1 << AW) - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.write_i = 1'b0; bus.write_address_i = '0; bus.write_data_i = '0; bus.write_strobe_i = '0;
    bus.read_i = 1'b0; bus.read_address_i = '0;
    tick = 1'b0;
    idle = '1;
    model_reset();
    #3;
    check_outputs();
    #9 rst_n = 1'b1;

    // Phase increment stays in shadow until a commit meets a sample tick.
    wr(TD + 16 + 1, 32'h0001_0000);
    check("freq1_before_commit", wave_frequency_o[1], 32'h0);
    wr(G, 32'h1);
    check("freq1_commit_no_tick", wave_frequency_o[1], 32'h0);
    rd(G);
    check("commit_pending_read", bus.read_data_o, 32'h1);
    tick_cycle();
    check("freq1_after_tick", wave_frequency_o[1], 32'h0001_0000);

    // Byte strobes.
    wr(TD + 3, 32'h1122_3344);
    wr(TD + 3, 32'hAABB_CCDD, 4'b0010);
    rd(TD + 3);
    check("duty_strobe_merge", bus.read_data_o, 32'h1122_CC44);

    // Arm bits produce one-cycle start pulses and self-clear.
    wr(TD + 0, 32'hC);
    wr(G, 32'h1);
    tick_cycle();
    check("wave_start0_pulse", 32'(wave_start_o[0]), 32'h1);
    check("adsr_start0_pulse", 32'(adsr_start_o[0]), 32'h1);
    cycle();
    check("wave_start0_done", 32'(wave_start_o[0]), 32'h0);
    check("adsr_start0_done", 32'(adsr_start_o[0]), 32'h0);
    rd(TD + 0);
    check("ctrl0_disarmed", bus.read_data_o, 32'h0);

    // Idle-edge interrupt, W1C clear, and edge winning over clear.
    wr(G + 3, 32'h4);
    idle[2] = 1'b0; cycle();
    idle[2] = 1'b1; cycle();
    cycle();
    check("irq_raised", 32'(irq_o), 32'h1);
    wr(G + 2, 32'h4);
    cycle();
    check("irq_cleared", 32'(irq_o), 32'h0);
    idle[2] = 1'b0; cycle();
    idle[2] = 1'b1;
    wr(G + 2, 32'h4);
    cycle();
    check("irq_edge_beats_clear", 32'(irq_o), 32'h1);
    rd(G + 2);
    check("irq_pending_read", bus.read_data_o, 32'h4);

    // PCM table write-through, table reads as zero.
    wr(5, 32'h1234_ABCD);
    check("table_write", 32'(table_write_o), 32'h1);
    check("table_addr5", 32'(table_addr_o), 32'd5);
    check("pcm_abcd", 32'(pcm_o), 32'h0000_ABCD);
    rd(5);
    check("table_write_done", 32'(table_write_o), 32'h0);
    check("table_read_zero", bus.read_data_o, 32'h0);

    // Reserved and unmapped writes are ignored.
    wr(TD + 16 * 2 + 12, 32'hDEAD_BEEF);
    rd(TD + 16 * 2 + 12);
    check("reserved_read_zero", bus.read_data_o, 32'h0);
    wr(G + 1, 32'hF);
    wr(G + 100, 32'hFFFF_FFFF);

    // Reset between COMMIT and tick discards the commit.
    wr(TD + 1, 32'h0000_7777);
    wr(G, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    wr(TD + 1, 32'h0000_5555);
    tick_cycle();
    check("no_commit_after_reset", wave_frequency_o[0], 32'h0);
    rd(G);
    check("commit_reads_zero", bus.read_data_o, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.write_i         = 1'b1;
        bus.write_address_i = AW'(rand_addr());
        bus.write_data_i    = $urandom;
        bus.write_strobe_i  = 4'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.read_i         = 1'b1;
        bus.read_address_i = AW'(rand_addr());
      end
      tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = int'($urandom_range(0, CH - 1));
        idle[k] = ~idle[k];
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
